// File: rtl/if_seg.sv
// Instruction-fetch segment: issues one outstanding imem request at a time and
// presents the fetched word and its PC+4 to decode, with a one-entry skid for stalls.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   FETCH | request at PC outstanding; deliver or skid the returned word
//   HOLD  | skid holds a word decode has not taken yet; no request issued
//   DRAIN | redirect arrived mid-request; wait out the stale ack at old address
`timescale 1ns/1ps
module if_seg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] NPCo,
    output logic [31:0] IRo,
    output logic        valid_o
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] skid_ir, skid_ir_nxt;
    logic [31:0] skid_npc, skid_npc_nxt;
    logic [31:0] ir_nxt, npc_nxt;
    logic        valid_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] br_pc;

    assign pc_plus4  = pc + 32'd4;
    assign br_pc     = br_target & 32'hFFFF_FFFC;
    // Request is gated by reset directly so nothing is issued while rst is low.
    assign imem_req  = rst && (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= 32'd0;
            skid_ir    <= 32'd0;
            skid_npc   <= 32'd0;
            IRo        <= 32'd0;
            NPCo       <= 32'd0;
            valid_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            skid_ir    <= skid_ir_nxt;
            skid_npc   <= skid_npc_nxt;
            IRo        <= ir_nxt;
            NPCo       <= npc_nxt;
            valid_o    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        skid_ir_nxt    = skid_ir;
        skid_npc_nxt   = skid_npc;
        ir_nxt         = IRo;
        npc_nxt        = NPCo;
        valid_nxt      = valid_o;

        case (state)
            FETCH: begin
                if (br_taken) begin
                    pc_nxt       = br_pc;
                    ir_nxt       = 32'd0;
                    valid_nxt    = 1'b0;
                    skid_ir_nxt  = 32'd0;
                    skid_npc_nxt = 32'd0;
                    if (!imem_ack) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc_plus4;
                    if (stall) begin
                        skid_ir_nxt  = imem_data;
                        skid_npc_nxt = pc_plus4;
                        state_nxt    = HOLD;
                    end else begin
                        ir_nxt    = imem_data;
                        npc_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    ir_nxt    = 32'd0;
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_nxt       = br_pc;
                    ir_nxt       = 32'd0;
                    valid_nxt    = 1'b0;
                    skid_ir_nxt  = 32'd0;
                    skid_npc_nxt = 32'd0;
                    state_nxt    = FETCH;
                end else if (!stall) begin
                    ir_nxt    = skid_ir;
                    npc_nxt   = skid_npc;
                    valid_nxt = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                // Outputs stay a bubble; a further redirect only retargets the PC.
                ir_nxt    = 32'd0;
                valid_nxt = 1'b0;
                if (br_taken) begin
                    pc_nxt = br_pc;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_seg.sv
// Bench for if_seg: directed scenarios with literal expectations, then random
// stall/redirect/latency traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_if_seg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] NPCo, IRo;
    logic        valid_o;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_data, w_npc, w_ir;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h2001_0005 + (a >> 2) * 32'h0001_0002;
    endfunction

    assign w_data = mem(w_addr);

    if_seg u_dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .NPCo(NPCo), .IRo(IRo), .valid_o(valid_o)
    );

    if_seg #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_data(w_data),
        .NPCo(w_npc), .IRo(w_ir), .valid_o(w_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the word waiting for decode is a queue, a redirect during
    // an unanswered request leaves a stale address that must be answered first.
    logic [31:0] m_pc = 32'd0, m_ir = 32'd0, m_npc = 32'd0;
    logic        m_valid = 1'b0;
    logic [63:0] m_wait[$];
    logic        m_stale = 1'b0;
    logic [31:0] m_stale_addr = 32'd0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_pc = 32'd0; m_ir = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
            m_wait.delete(); m_stale = 1'b0;
        end else begin
            logic [31:0] tgt;
            tgt = {br_target[31:2], 2'b00};
            if (m_wait.size() != 0) begin
                if (br_taken) begin
                    m_wait.delete(); m_pc = tgt; m_ir = 32'd0; m_valid = 1'b0;
                end else if (!stall) begin
                    {m_ir, m_npc} = m_wait.pop_front(); m_valid = 1'b1;
                end
            end else if (m_stale) begin
                if (br_taken) m_pc = tgt;
                if (imem_ack) m_stale = 1'b0;
                m_ir = 32'd0; m_valid = 1'b0;
            end else if (br_taken) begin
                if (!imem_ack) begin m_stale = 1'b1; m_stale_addr = m_pc; end
                m_pc = tgt; m_ir = 32'd0; m_valid = 1'b0;
            end else if (imem_ack) begin
                if (stall) m_wait.push_back({imem_data, m_pc + 32'd4});
                else begin m_ir = imem_data; m_npc = m_pc + 32'd4; m_valid = 1'b1; end
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                m_ir = 32'd0; m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        exp_req = rst && (m_wait.size() == 0);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        chk("IRo", IRo, m_ir);
        chk("NPCo", NPCo, m_npc);
        if (valid_o === 1'b1) chk("IRo_vs_NPCo", IRo, mem(NPCo - 32'd4));
    end

    // a >= 0: drive that ack; a < 0: memory answers with random latency.
    task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] t, input int a);
        @(posedge clk);
        #2;
        rst = r; stall = s; br_taken = b; br_target = t;
        #1;
        if (a >= 0) imem_ack = (a != 0);
        else if (imem_req) begin
            if (lat == 0) begin imem_ack = 1'b1; lat = $urandom_range(0, 3); end
            else begin imem_ack = 1'b0; lat--; end
        end else imem_ack = rst && ($urandom_range(0, 3) == 0);
        imem_data = mem(imem_addr);
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) tick(0, 0, 0, 0, 1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_IRo", IRo, 32'd0);
        chk("rst_NPCo", NPCo, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        tick(1, 0, 0, 0, 1);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_first_req", {31'd0, w_req}, 32'd1);
        tick(1, 0, 0, 0, 1);
        chk("seq_IR0", IRo, 32'h2001_0005);
        chk("seq_NPC0", NPCo, 32'd4);
        chk("seq_valid0", {31'd0, valid_o}, 32'd1);
        chk("wrap_NPC", w_npc, 32'd0);
        chk("wrap_IR", w_ir, mem(32'hFFFF_FFFC));
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_second_addr", w_addr, 32'd0);
        tick(1, 1, 0, 0, 1);
        chk("seq_IR1", IRo, 32'h2002_0007);
        chk("seq_NPC1", NPCo, 32'd8);
        chk("stall_addr", imem_addr, 32'd8);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) tick(1, 1, 0, 0, 0);
            else tick(1, 0, 0, 0, 0);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_IR", IRo, 32'h2002_0007);
            chk("hold_NPC", NPCo, 32'd8);
        end
        tick(1, 0, 0, 0, 0);
        chk("release_IR", IRo, 32'h2003_0009);
        chk("release_NPC", NPCo, 32'd12);
        chk("release_addr", imem_addr, 32'd12);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, (i == 2) ? 1 : 0);
            chk("wait_addr", imem_addr, 32'd12);
            chk("wait_valid", {31'd0, valid_o}, 32'd0);
        end
        tick(1, 0, 0, 0, 0);
        chk("late_IR", IRo, 32'h2004_000B);
        chk("late_NPC", NPCo, 32'd16);
        tick(1, 0, 1, 32'h40, 0);
        tick(1, 0, 0, 0, 0);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_valid", {31'd0, valid_o}, 32'd0);
        chk("drain_IR", IRo, 32'd0);
        tick(1, 0, 0, 0, 1);
        chk("drain_addr2", imem_addr, 32'h10);
        tick(1, 1, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'd0, valid_o}, 32'd0);
        tick(1, 1, 1, 32'h83, 0);
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        tick(1, 0, 0, 0, 0);
        chk("brstall_valid", {31'd0, valid_o}, 32'd0);
        chk("brstall_IR", IRo, 32'd0);
        chk("brstall_addr", imem_addr, 32'h80);
        tick(0, 0, 0, 0, 1);
        chk("midrst_NPC", NPCo, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        tick(1, 0, 0, 0, 0);
        chk("refetch_addr", imem_addr, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 399) != 0);
            tick(r, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 7), $urandom, -1);
        end
        tick(1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
